uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Upstream feeder for `uart_tx`. Accepts 32-bit result words (e.g. FPU outputs) over a valid/ready interface and buffers them in a small FIFO. Each word goes out as a 6-byte framed packet, one byte per `uart_tx` transaction, pacing itself on `uart_busy`. It lets the FPU test harness stream results to the host without tracking byte-level UART timing.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, 2..16.
- `SYNC`, 8'hA5: frame start byte.
- `clk`  in  1  system clock, the same clock that drives `uart_tx`.
- `rst`  in  1  synchronous, active-low reset. Sampled on `posedge clk`; `rst==0` resets the block.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  32  upstream word.
- `in_ready`  out  1  FIFO can accept a word this cycle.
- `tx_en`  out  1  one-cycle request to `uart_tx`.
- `tx_data`  out  8  byte presented with `tx_en`.
- `uart_busy`  in  1  busy flag from `uart_tx`.
- `fifo_count`  out  $clog2(DEPTH)+1  words currently stored.
- `pkt_done`  out  1  one-cycle pulse when the last byte of a packet has been handed to `uart_tx`.
- `overflow`  out  1  sticky flag: `in_valid` was seen while `in_ready==0`.

## Operation
- **Packet format per word W:** `SYNC`, W[31:24], W[23:16], W[15:8], W[7:0], then CHK = W[31:24]^W[23:16]^W[15:8]^W[7:0]. `SYNC` is excluded from CHK.
- **FIFO:** circular buffer with read/write pointers and a count.
  - Push when `in_valid & in_ready`.
  - `in_ready = (fifo_count != DEPTH)`. There is no same-cycle pop bypass when full.
  - A word offered while full is dropped and `overflow` is set. `overflow` clears only on reset.
- **FSM states:**
  - **IDLE:** if `fifo_count != 0`, go to LOAD.
  - **LOAD:** pop the head word into a 32-bit holding register, compute CHK, set byte index to 0, go to SEND.
  - **SEND:** if `uart_busy==0`, drive `tx_en=1` and `tx_data = byte[index]` for exactly this cycle, then go to WAIT_HI. Otherwise stay in SEND with `tx_en=0`.
  - **WAIT_HI:** wait for `uart_busy==1`, then go to WAIT_LO. `uart_tx` raises busy the cycle after it accepts a byte.
  - **WAIT_LO:** wait for `uart_busy==0`.
    - If index != 5: increment index and go to SEND.
    - If index == 5: pulse `pkt_done` and go to LOAD if `fifo_count != 0`, else IDLE.
- Push and pop in the same cycle leave the count unchanged. Both pointers wrap modulo DEPTH.
- `tx_data` holds its last value outside SEND. It is only meaningful when `tx_en==1`.

## Timing
- **Reset values:**
  - `tx_en=0`, `tx_data=8'h00`, `pkt_done=0`, `overflow=0`.
  - `fifo_count=0`, `in_ready=1`, FSM in IDLE, pointers at 0.
- **Reset mid-packet:** the packet is abandoned, the FIFO is emptied, and no further `tx_en` is issued. Any byte already inside `uart_tx` completes on its own.
- **First-byte latency:** word pushed at cycle N (FIFO empty, FSM idle, `uart_busy==0`):
  - IDLE sees count at N+1.
  - LOAD at N+2.
  - SEND with `tx_en` at N+3.
- **Handshake:** `tx_en` is never asserted while `uart_busy==1`, and never on two consecutive cycles.
- **Inter-byte spacing:** set by `uart_tx`, plus 2 cycles of FSM overhead (WAIT_LO→SEND, SEND).
- **Back-to-back packets:** LOAD follows WAIT_LO directly with no IDLE cycle.
- **Registered outputs:** `pkt_done` is registered, asserted in the cycle after the WAIT_LO exit condition. `in_ready` and `fifo_count` reflect registered count.

## Test plan
- **Single word:** reset, then push 32'h12345678 with a `uart_tx` model.
  - Required: bytes A5,12,34,56,78,08 in order.
  - Required: exactly 6 `tx_en` pulses and one `pkt_done` after the sixth.
- **Fill to full:** push 4 words in 4 consecutive cycles (DEPTH=4) while `uart_busy` is held high.
  - Required: `fifo_count` reaches 4 (3 if a pop occurred) and `in_ready` goes low when full.
  - A fifth `in_valid` while full sets `overflow` and that word is never transmitted.
- **Busy stall:** hold `uart_busy=1` for 100 cycles while in SEND.
  - Required: `tx_en` stays 0 throughout, and the byte is issued on the first cycle `uart_busy==0`.
- **Back-to-back packets:** push 32'hFFFFFFFF and 32'h00000000.
  - Required: A5,FF,FF,FF,FF,00 then A5,00,00,00,00,00.
  - Required: two `pkt_done` pulses and no IDLE cycle between the packets.
- **Simultaneous push/pop:** push a word in the same cycle as LOAD pops one.
  - Required: `fifo_count` unchanged and data order preserved across pointer wrap (push 6 words total with DEPTH=4).
- **Reset mid-packet:** drive `rst=0` for one cycle after the third byte.
  - Required: all outputs return to reset values the next cycle, `fifo_count=0`, and no further `tx_en` appears until a new word is pushed.

Source files
------------

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit words in a FIFO and streams each as a 6-byte
// framed packet (SYNC, 4 data bytes MSB first, XOR checksum) into uart_tx.
module uart_word_tx #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  input  logic                     uart_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     pkt_done,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_word;
  logic [7:0]    r_chk;
  logic [2:0]    r_idx;
  logic [7:0]    r_tx_data;
  logic          r_pkt_done, r_overflow;
  logic          w_push, w_pop, w_last;
  logic [31:0]   w_head;
  logic [7:0]    w_next_byte;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = (r_state == LOAD);
  assign w_last     = (r_idx == 3'd5);
  assign w_head     = r_mem[r_rptr];
  assign in_ready   = (r_count != (AW+1)'(DEPTH));
  assign fifo_count = r_count;
  assign tx_en      = (r_state == SEND) & ~uart_busy;
  assign tx_data    = r_tx_data;
  assign pkt_done   = r_pkt_done;
  assign overflow   = r_overflow;
  // byte that follows the one at r_idx; index 4 -> checksum
  always_comb begin
    w_next_byte = (r_idx == 3'd0) ? r_word[31:24] :
                  (r_idx == 3'd1) ? r_word[23:16] :
                  (r_idx == 3'd2) ? r_word[15:8]  :
                  (r_idx == 3'd3) ? r_word[7:0]   : r_chk;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_word     <= '0;
      r_chk      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_pkt_done <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_overflow <= r_overflow | (in_valid & ~in_ready);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      case (r_state)
        IDLE: if (r_count != '0) r_state <= LOAD;
        LOAD: begin
          r_word    <= w_head;
          r_chk     <= w_head[31:24] ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
          r_idx     <= '0;
          r_tx_data <= SYNC;
          r_state   <= SEND;
        end
        SEND:    if (!uart_busy) r_state <= WAIT_HI;
        WAIT_HI: if (uart_busy) r_state <= WAIT_LO;
        WAIT_LO: begin
          if (!uart_busy && w_last) begin
            r_pkt_done <= 1'b1;
            r_state    <= (r_count != '0) ? LOAD : IDLE;
          end else if (!uart_busy) begin
            r_idx     <= r_idx + 3'd1;
            r_tx_data <= w_next_byte;
            r_state   <= SEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench with a small uart_tx busy model and a byte monitor.
module tb_uart_word_tx;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, force_busy = 1'b0;
  logic        m_busy = 1'b0, prev_en = 1'b0;
  logic [2:0]  m_cnt = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, tx_en, uart_busy, pkt_done, overflow;
  logic [7:0]  tx_data;
  logic [2:0]  fifo_count;
  int          n_assert = 0, n_fail = 0, viol = 0, cyc = 0;
  logic [7:0]  byte_q[$];
  int          txcyc_q[$], pkt_q[$], pktcyc_q[$];

  uart_word_tx #(.DEPTH(4), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_en(tx_en), .tx_data(tx_data),
    .uart_busy(uart_busy), .fifo_count(fifo_count),
    .pkt_done(pkt_done), .overflow(overflow)
  );

  assign uart_busy = m_busy | force_busy;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy rises the cycle after a request and stays up a few cycles
  always @(posedge clk) begin
    if (tx_en) begin
      m_busy <= 1'b1;
      m_cnt  <= 3'd6;
    end else if (m_cnt != 0) m_cnt <= m_cnt - 3'd1;
    else m_busy <= 1'b0;
  end

  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      if (uart_busy || prev_en) viol <= viol + 1;
      byte_q.push_back(tx_data);
      txcyc_q.push_back(cyc);
    end
    if (pkt_done === 1'b1) begin
      pkt_q.push_back(byte_q.size());
      pktcyc_q.push_back(cyc);
    end
    prev_en <= (tx_en === 1'b1);
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    case (i)
      0: return 8'hA5;
      1: return w[31:24];
      2: return w[23:16];
      3: return w[15:8];
      4: return w[7:0];
      default: return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int k = 0; k < budget && pkt_q.size() < n; k++) tick();
    chk("pkt_wait", pkt_q.size(), n);
  endtask

  task automatic check_pkt(input logic [31:0] w, input int base);
    for (int i = 0; i < 6; i++)
      chk($sformatf("byte%0d_%h", i, w),
          (base + i < byte_q.size()) ? {24'h0, byte_q[base+i]} : 32'hFFFF_FFFF,
          {24'h0, exp_byte(w, i)});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int base, pb;
    logic [31:0] fill_w [5];
    fill_w = '{32'h01020304, 32'h10203040, 32'hAABBCCDD, 32'h0F0E0D0C, 32'h55667788};
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // single word, first-byte latency
    base = byte_q.size();
    push(32'h12345678);
    chk("lat_n1_count", fifo_count, 1);
    chk("lat_n1_tx_en", tx_en, 0);
    tick();
    chk("lat_n2_tx_en", tx_en, 0);
    tick();
    chk("lat_n3_tx_en", tx_en, 1);
    chk("lat_n3_tx_data", tx_data, 8'hA5);
    chk("lat_n3_count", fifo_count, 0);
    wait_pkts(1, 300);
    for (int k = 0; k < 20; k++) tick();
    chk("single_byte_count", byte_q.size() - base, 6);
    chk("single_chk_byte", (base + 5 < byte_q.size()) ? byte_q[base+5] : 8'hFF, 8'h08);
    check_pkt(32'h12345678, base);
    chk("single_done_after_6th", pkt_q[0] - base, 6);

    // busy stall while sitting in SEND
    base = byte_q.size();
    force_busy = 1'b1;
    push(32'hCAFEF00D);
    for (int k = 0; k < 100; k++) tick();
    chk("stall_no_bytes", byte_q.size() - base, 0);
    chk("stall_tx_en", tx_en, 0);
    force_busy = 1'b0;
    #1;
    chk("stall_release_tx_en", tx_en, 1);
    chk("stall_release_data", tx_data, 8'hA5);
    wait_pkts(2, 300);
    check_pkt(32'hCAFEF00D, base);
    chk("stall_chk_byte", (base + 5 < byte_q.size()) ? byte_q[base+5] : 8'hFF, 8'hC9);

    // fill to full, overflow, push/pop overlap and pointer wrap
    base = byte_q.size();
    force_busy = 1'b1;
    push(fill_w[0]);
    chk("fill_c1", fifo_count, 1);
    push(fill_w[1]);
    chk("fill_c2", fifo_count, 2);
    push(fill_w[2]);
    chk("fill_pushpop_c2", fifo_count, 2);
    push(fill_w[3]);
    chk("fill_c3", fifo_count, 3);
    chk("fill_ready_c3", in_ready, 1);
    push(fill_w[4]);
    chk("fill_c4", fifo_count, 4);
    chk("fill_ready_full", in_ready, 0);
    chk("fill_ovf_before", overflow, 0);
    push(32'hDEADBEEF);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_set", overflow, 1);
    force_busy = 1'b0;
    wait_pkts(7, 2000);
    for (int k = 0; k < 20; k++) tick();
    chk("fill_total_bytes", byte_q.size() - base, 30);
    for (int p = 0; p < 5; p++) check_pkt(fill_w[p], base + 6 * p);
    chk("ovf_sticky", overflow, 1);

    // back-to-back packets with no idle gap
    base = byte_q.size();
    pb   = pkt_q.size();
    push(32'hFFFFFFFF);
    push(32'h00000000);
    wait_pkts(pb + 2, 500);
    check_pkt(32'hFFFFFFFF, base);
    check_pkt(32'h00000000, base + 6);
    chk("b2b_gap", txcyc_q[base+6] - pktcyc_q[pb], 1);
    chk("b2b_done2_pos", pkt_q[pb+1] - base, 12);

    // reset mid-packet after the third byte
    base = byte_q.size();
    pb   = pkt_q.size();
    push(32'h13579BDF);
    push(32'h2468ACE0);
    for (int k = 0; k < 300 && byte_q.size() < base + 3; k++) tick();
    chk("mid_three_bytes", byte_q.size() - base, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_vals("midrst");
    for (int k = 0; k < 100; k++) tick();
    chk("midrst_no_tx", byte_q.size() - base, 3);
    chk("midrst_no_done", pkt_q.size(), pb);
    base = byte_q.size();
    push(32'h0BADF00D);
    wait_pkts(pb + 1, 300);
    check_pkt(32'h0BADF00D, base);

    chk("handshake_viol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
